// File: rtl/seq_divider.sv
// Multicycle signed restoring divider (div/divu): quotient on LO_Out, remainder on HI_Out.
// Optional macro DIV_UNSIGNED_EN adds the Div_Unsigned port for divu support.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Div_Control,
  input  logic [WIDTH-1:0] A_In,
  input  logic [WIDTH-1:0] B_In,
`ifdef DIV_UNSIGNED_EN
  input  logic             Div_Unsigned,
`endif
  output logic             Busy,
  output logic             Done,
  output logic             Div_Zero,
  output logic [WIDTH-1:0] HI_Out,
  output logic [WIDTH-1:0] LO_Out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ITER, S_FIX, S_DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             uns;
  } req_t;

  state_t           r_state, w_next;
  req_t             r_req, w_req;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_rem, r_hi, r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_qneg, r_rneg, r_dz;

  logic             w_accept, w_zero, w_ge;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;
  logic [WIDTH:0]   w_shift, w_diff;

  always_comb begin
    w_req.a   = A_In;
    w_req.b   = B_In;
`ifdef DIV_UNSIGNED_EN
    w_req.uns = Div_Unsigned;
`else
    w_req.uns = 1'b0;
`endif
  end

  assign w_accept = (r_state == S_IDLE) && Div_Control;
  assign w_zero   = (B_In == '0);

  // 0x80..0 negates to itself and is then read as unsigned 2^(WIDTH-1).
  assign w_a_abs = (!r_req.uns && r_req.a[WIDTH-1]) ? (~r_req.a + 1'b1) : r_req.a;
  assign w_b_abs = (!r_req.uns && r_req.b[WIDTH-1]) ? (~r_req.b + 1'b1) : r_req.b;

  // Shifted partial remainder kept one bit wider so large unsigned divisors compare correctly.
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    Busy   = 1'b0;
    Done   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_accept && !w_zero) w_next = S_SETUP;
      S_SETUP: begin
        Busy   = 1'b1;
        w_next = S_ITER;
      end
      S_ITER: begin
        Busy = 1'b1;
        if (r_cnt == '0) w_next = S_FIX;
      end
      S_FIX: begin
        Busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_req  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_dz <= w_accept && w_zero;
      if (w_accept && !w_zero) r_req <= w_req;
      case (r_state)
        S_SETUP: begin
          r_dvd  <= w_a_abs;
          r_dvs  <= w_b_abs;
          r_rem  <= '0;
          r_cnt  <= CW'(WIDTH - 1);
          r_qneg <= !r_req.uns && (r_req.a[WIDTH-1] ^ r_req.b[WIDTH-1]);
          r_rneg <= !r_req.uns && r_req.a[WIDTH-1];
        end
        S_ITER: begin
          // Quotient bits shift into the dividend register as it empties.
          r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_lo <= r_qneg ? (~r_dvd + 1'b1) : r_dvd;
          r_hi <= r_rneg ? (~r_rem + 1'b1) : r_rem;
        end
        default: ;
      endcase
    end
  end

  assign Div_Zero = r_dz;
  assign HI_Out   = r_hi;
  assign LO_Out   = r_lo;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor pops on Done/Div_Zero.
// Build with DIV_UNSIGNED_EN defined to also exercise the divu vectors.
module tb_seq_divider;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Div_Control = 1'b0;
  logic [W-1:0] A_In = '0;
  logic [W-1:0] B_In = '0;
`ifdef DIV_UNSIGNED_EN
  logic         Div_Unsigned = 1'b0;
`endif
  logic         Busy, Done, Div_Zero;
  logic [W-1:0] HI_Out, LO_Out;

  seq_divider #(.WIDTH(W)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Div_Control (Div_Control),
    .A_In        (A_In),
    .B_In        (B_In),
`ifdef DIV_UNSIGNED_EN
    .Div_Unsigned(Div_Unsigned),
`endif
    .Busy        (Busy),
    .Done        (Done),
    .Div_Zero    (Div_Zero),
    .HI_Out      (HI_Out),
    .LO_Out      (LO_Out)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    logic         zero;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           start;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every Done or Div_Zero pulse must match the oldest expected entry.
  logic prev_done = 1'b0;
  logic prev_dz   = 1'b0;
  always @(negedge Clock) begin
    exp_t e;
    if (Reset) begin
      if (prev_done) check("done_one_cycle", {31'b0, Done}, 32'd0);
      if (prev_dz)   check("div_zero_one_cycle", {31'b0, Div_Zero}, 32'd0);
      if (Done || Div_Zero) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: done=%b div_zero=%b lo=%h hi=%h", Done, Div_Zero, LO_Out, HI_Out);
        end else begin
          e = sb.pop_front();
          check({e.name, "_div_zero"}, {31'b0, Div_Zero}, {31'b0, e.zero});
          check({e.name, "_done"}, {31'b0, Done}, {31'b0, !e.zero});
          check({e.name, "_lo"}, LO_Out, e.lo);
          check({e.name, "_hi"}, HI_Out, e.hi);
          check({e.name, "_latency"}, 32'(cyc - e.start), e.zero ? 32'd0 : 32'(LAT));
          check({e.name, "_busy"}, {31'b0, Busy}, 32'd0);
        end
      end
    end
    prev_done <= Done;
    prev_dz   <= Div_Zero;
  end

  task automatic start(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic uns, input bit push,
                       input logic [W-1:0] elo, input logic [W-1:0] ehi);
    exp_t e;
    @(negedge Clock);
    A_In        = a;
    B_In        = b;
    Div_Control = 1'b1;
`ifdef DIV_UNSIGNED_EN
    Div_Unsigned = uns;
`else
    if (uns) $display("note: unsigned vector %s run as signed", nm);
`endif
    if (push) begin
      e.zero  = (b == '0);
      e.lo    = elo;
      e.hi    = ehi;
      e.start = cyc + 1;
      e.name  = nm;
      sb.push_back(e);
    end
    @(negedge Clock);
    Div_Control = 1'b0;
    A_In        = $urandom;
    B_In        = $urandom;
    if (push) check({nm, "_busy_after_start"}, {31'b0, Busy}, {31'b0, (b != '0)});
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 4 * LAT && sb.size() != 0; i++) @(negedge Clock);
    check({nm, "_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic div(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic uns, input logic [W-1:0] elo, input logic [W-1:0] ehi);
    start(nm, a, b, uns, 1'b1, elo, ehi);
    drain(nm);
  endtask

  initial begin
    #2 Reset = 1'b0;
    repeat (2) @(negedge Clock);
    check("reset_busy", {31'b0, Busy}, 32'd0);
    check("reset_done", {31'b0, Done}, 32'd0);
    check("reset_div_zero", {31'b0, Div_Zero}, 32'd0);
    check("reset_hi", HI_Out, 32'd0);
    check("reset_lo", LO_Out, 32'd0);
    Reset = 1'b1;

    div("pos_7_2",     32'd7,          32'd2,          1'b0, 32'd3,          32'd1);
    div("zero_div",    32'd5,          32'd0,          1'b0, 32'd3,          32'd1);
    div("neg_7_2",     32'hFFFF_FFF9,  32'd2,          1'b0, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
    div("pos_7_neg2",  32'd7,          32'hFFFF_FFFE,  1'b0, 32'hFFFF_FFFD,  32'd1);
    div("min_neg1",    32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  32'd0);
    div("zero_dvd",    32'd0,          32'd5,          1'b0, 32'd0,          32'd0);
    div("neg100_7",    32'hFFFF_FF9C,  32'd7,          1'b0, 32'hFFFF_FFF2,  32'hFFFF_FFFE);
    div("neg8_neg3",   32'hFFFF_FFF8,  32'hFFFF_FFFD,  1'b0, 32'd2,          32'hFFFF_FFFE);
    div("max_min",     32'h7FFF_FFFF,  32'h8000_0000,  1'b0, 32'd0,          32'h7FFF_FFFF);
    div("min_min",     32'h8000_0000,  32'h8000_0000,  1'b0, 32'd1,          32'd0);

    // A second start while busy must be ignored.
    start("busy_ignore", 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2);
    repeat (8) @(negedge Clock);
    A_In = 32'd9; B_In = 32'd3; Div_Control = 1'b1;
    @(negedge Clock);
    Div_Control = 1'b0;
    drain("busy_ignore");

    // Reset mid-operation clears everything and suppresses Done.
    start("mid_reset", 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (4) @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("mid_reset_busy", {31'b0, Busy}, 32'd0);
    check("mid_reset_done", {31'b0, Done}, 32'd0);
    check("mid_reset_hi", HI_Out, 32'd0);
    check("mid_reset_lo", LO_Out, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (LAT + 6) @(negedge Clock);
    div("after_reset", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

`ifdef DIV_UNSIGNED_EN
    div("divu_m1_2",   32'hFFFF_FFFF, 32'd2,          1'b1, 32'h7FFF_FFFF, 32'd1);
    div("div_m1_2",    32'hFFFF_FFFF, 32'd2,          1'b0, 32'd0,         32'hFFFF_FFFF);
    div("divu_big",    32'hFFFF_FFFF, 32'h8000_0000,  1'b1, 32'd1,         32'h7FFF_FFFF);
    div("divu_big2",   32'hFFFF_FFFF, 32'h8000_0001,  1'b1, 32'd1,         32'h7FFF_FFFE);
`endif

    repeat (3) @(negedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
